delta_addr_gen: RTL and testbench
=================================

// Module: delta_addr_gen
// PURPOSE
// - Counter/address datapath paired with the delta-cepstrum state controller: consumes its control strobes
//   (counter_en/counter_value, sel_n, sel_addr, inc_cep_en, inc_frame_en, write_delta_en), returns counter_over,
//   counter_cep_over, counter_frame_over.
// - Generates cepstral-memory read addresses for frames n-1/n+1/n-2/n+2 (edge-clamped) and delta-memory addresses.
// PARAMETERS
// - NUM_CEP     13  cepstral coefficients per frame
// - NUM_FRAME   99  frames per utterance
// - CEP_AW      4   cep index width
// - FRAME_AW    7   frame index width
// - ADDR_WIDTH  11  memory address width (>= clog2(NUM_CEP*NUM_FRAME))
// PORTS
// - clk                 in   1           clock, rising edge
// - rst                 in   1           asynchronous reset, active-high
// - start               in   1           sync clear of indices/counter (pulse with delta_state_en)
// - counter_en          in   1           cycle counter run
// - counter_value       in   4           cycles per state (0 treated as 1)
// - sel_n               in   2           00:n-1 01:n+1 10:n-2 11:n+2
// - sel_addr            in   1           0: cep read addr; 1: current frame n
// - inc_cep_en          in   1           advance cep index
// - inc_frame_en        in   1           advance frame index
// - write_delta_en      in   1           controller WRITE phase
// - counter_over        out  1           state cycle budget reached
// - counter_cep_over    out  1           cep_idx == NUM_CEP-1
// - counter_frame_over  out  1           frame_idx == NUM_FRAME-1
// - rd_addr             out  ADDR_WIDTH  registered read address
// - wr_addr             out  ADDR_WIDTH  registered delta write address
// - wr_en               out  1           one-cycle write strobe
// - cep_idx             out  CEP_AW      current coefficient index
// - frame_idx           out  FRAME_AW    current frame index
// BEHAVIOUR
// - Reset (async, rst=1): cnt, cep_idx, frame_idx, frame_base, rd_addr, wr_addr, wr_en, write_d all 0;
//   counter_over=0, counter_cep_over=(NUM_CEP==1), counter_frame_over=(NUM_FRAME==1).
//   Reset mid-operation aborts immediately.
// - Cycle counter: counter_en=0 -> cnt<=0, counter_over=0. counter_en=1 -> counter_over (combinational) =
//   (cnt == max(counter_value,1)-1); on over cnt<=0, else cnt<=cnt+1.
//   Back-to-back states each get a full count; no idle cycle.
// - Index update, priority: start > inc_frame_en > inc_cep_en.
//   - start: cep_idx<=0, frame_idx<=0, frame_base<=0, cnt<=0.
//   - inc_frame_en (controller also raises inc_cep_en): cep_idx<=0, frame_idx<=frame_idx+1,
//     frame_base<=frame_base+NUM_CEP; wrap at NUM_FRAME-1 to 0/0.
//   - inc_cep_en alone: cep_idx+1, wrap NUM_CEP-1 -> 0 (frame unchanged).
// - Address arithmetic: no multiplier; frame_base tracks frame_idx*NUM_CEP.
//   - Offset frame f = frame_idx + {-1,+1,-2,+2}[sel_n], clamped to [0, NUM_FRAME-1] (edge replication).
//     Base = frame_base + {-1,+1,-2,+2}*NUM_CEP, substituted by 0 / (NUM_FRAME-1)*NUM_CEP when clamped.
//   - Unsigned, ADDR_WIDTH bits; intermediate one bit wider signed; no overflow for legal parameters.
//   - rd_addr <= (sel_addr ? frame_base : clamped_base) + cep_idx; latency 1 cycle from any input/index change.
// - Write: write_d <= write_delta_en; wr_en <= write_delta_en & ~write_d (exactly one pulse per WRITE state,
//   lands 1 cycle after entry). wr_addr <= frame_base + cep_idx, sampled with the same edge.
// - Flags counter_cep_over/counter_frame_over are combinational from registered indices: valid in BRANCH states.
// - Simultaneous start + counter_en: cnt cleared, counter_over evaluated on old cnt that cycle.
// STRUCTURE
// - Shared package delta_pkg: sel_n encodings (SEL_NM1, SEL_NP1, SEL_NM2, SEL_NP2), LOOPS_READ/SUB/MUL/ADD/WRITE
//   constants, NUM_CEP/NUM_FRAME defaults; the controller imports the same package.
// - One sub-module: delta_cycle_counter (cnt + counter_over). Address/index logic stays in the top.
// TESTING
// - Reset: rst=1 mid-count (cnt=2) -> next cycle cnt=0, rd_addr=0, wr_en=0, counter_over=0; hold after release.
// - Counter: counter_en=1, counter_value=3 -> counter_over high on cycles 3,6,9; counter_value=0 -> high every cycle.
// - Clamping, NUM_CEP=13, NUM_FRAME=4, frame 0, cep 5:
//   - sel_n=10 -> rd_addr=5; sel_n=00 -> 5; sel_n=11 -> 31; sel_n=01 -> 18.
//   - Frame 3: sel_n=11 -> 44; sel_n=10 -> 18.
// - INC_FRAME (inc_frame_en=inc_cep_en=1) at frame 1, cep 12 -> frame 2, cep 0, counter_cep_over 1->0,
//   sel_addr=1 rd_addr=26.
// - WRITE held 2 cycles at frame 2, cep 4 -> single wr_en pulse, wr_addr=30; second WRITE entry -> second pulse.
// - Full sweep (13x4 via controller model) -> counter_frame_over&counter_cep_over exactly once, 52 wr_en pulses,
//   wr_addr 0..51 in order.

Source files
------------

// File: rtl/delta_pkg.sv
// Shared constants for the delta-cepstrum controller and its address/counter datapath.
package delta_pkg;

  localparam int NUM_CEP_DEF   = 13;
  localparam int NUM_FRAME_DEF = 99;

  typedef enum logic [1:0] {
    SEL_NM1 = 2'b00,
    SEL_NP1 = 2'b01,
    SEL_NM2 = 2'b10,
    SEL_NP2 = 2'b11
  } sel_n_e;

  // Cycle budgets the controller drives onto counter_value for each state.
  localparam logic [3:0] LOOPS_READ  = 4'd2;
  localparam logic [3:0] LOOPS_SUB   = 4'd1;
  localparam logic [3:0] LOOPS_MUL   = 4'd3;
  localparam logic [3:0] LOOPS_ADD   = 4'd1;
  localparam logic [3:0] LOOPS_WRITE = 4'd2;

endpackage

// File: rtl/delta_cycle_counter.sv
// Per-state cycle counter: raises over_o on the last cycle of the programmed budget.
module delta_cycle_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] value_i,
  output logic          over_o
);

  logic [CW-1:0] cnt_q, cnt_d, lim;

  // A zero budget behaves like one cycle per state.
  assign lim    = (value_i == '0) ? '0 : value_i - CW'(1);
  assign over_o = en_i & (cnt_q == lim);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || !en_i || over_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/delta_addr_gen.sv
// Index/address datapath for the delta-cepstrum engine: frame/cep indices, edge-clamped
// neighbour-frame read addresses and single-pulse delta write addresses.
module delta_addr_gen
  import delta_pkg::*;
#(
  parameter int NUM_CEP    = NUM_CEP_DEF,
  parameter int NUM_FRAME  = NUM_FRAME_DEF,
  parameter int CEP_AW     = 4,
  parameter int FRAME_AW   = 7,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  counter_en,
  input  logic [3:0]            counter_value,
  input  logic [1:0]            sel_n,
  input  logic                  sel_addr,
  input  logic                  inc_cep_en,
  input  logic                  inc_frame_en,
  input  logic                  write_delta_en,
  output logic                  counter_over,
  output logic                  counter_cep_over,
  output logic                  counter_frame_over,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic [CEP_AW-1:0]     cep_idx,
  output logic [FRAME_AW-1:0]   frame_idx
);

  localparam int SW = ADDR_WIDTH + 1;
  localparam int FW = FRAME_AW + 2;
  localparam logic signed [FW-1:0]         FMAX      = FW'(NUM_FRAME - 1);
  localparam logic [ADDR_WIDTH-1:0]        LAST_BASE = ADDR_WIDTH'((NUM_FRAME - 1) * NUM_CEP);

  logic [CEP_AW-1:0]     cep_q, cep_d;
  logic [FRAME_AW-1:0]   frame_q, frame_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d, wr_addr_q, wr_addr_d, clamped;
  logic                  wr_en_q, write_q;
  logic signed [FW-1:0]  fd, f_s;
  logic signed [SW-1:0]  off, base_s;

  delta_cycle_counter #(.CW(4)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start),
    .en_i    (counter_en),
    .value_i (counter_value),
    .over_o  (counter_over)
  );

  assign counter_cep_over   = (cep_q == CEP_AW'(NUM_CEP - 1));
  assign counter_frame_over = (frame_q == FRAME_AW'(NUM_FRAME - 1));

  always_comb begin
    cep_d   = cep_q;
    frame_d = frame_q;
    base_d  = base_q;
    if (start) begin
      cep_d   = '0;
      frame_d = '0;
      base_d  = '0;
    end else if (inc_frame_en) begin
      cep_d = '0;
      if (counter_frame_over) begin
        frame_d = '0;
        base_d  = '0;
      end else begin
        frame_d = frame_q + FRAME_AW'(1);
        base_d  = base_q + ADDR_WIDTH'(NUM_CEP);
      end
    end else if (inc_cep_en) begin
      cep_d = counter_cep_over ? '0 : cep_q + CEP_AW'(1);
    end
  end

  // Neighbour frame offsets; base offsets are constant multiples so no multiplier appears.
  always_comb begin
    fd  = '0;
    off = '0;
    case (sel_n_e'(sel_n))
      SEL_NM1: begin fd = FW'(-1); off = SW'(-NUM_CEP);     end
      SEL_NP1: begin fd = FW'(1);  off = SW'(NUM_CEP);      end
      SEL_NM2: begin fd = FW'(-2); off = SW'(-2 * NUM_CEP); end
      SEL_NP2: begin fd = FW'(2);  off = SW'(2 * NUM_CEP);  end
      default: ;
    endcase
    f_s    = $signed({2'b00, frame_q}) + fd;
    base_s = $signed({1'b0, base_q}) + off;
    if (f_s[FW-1])       clamped = '0;
    else if (f_s > FMAX) clamped = LAST_BASE;
    else                 clamped = base_s[ADDR_WIDTH-1:0];
    rd_d      = (sel_addr ? base_q : clamped) + ADDR_WIDTH'(cep_q);
    wr_addr_d = (write_delta_en && !write_q) ? base_q + ADDR_WIDTH'(cep_q) : wr_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cep_q     <= '0;
      frame_q   <= '0;
      base_q    <= '0;
      rd_q      <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      write_q   <= 1'b0;
    end else begin
      cep_q     <= cep_d;
      frame_q   <= frame_d;
      base_q    <= base_d;
      rd_q      <= rd_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= write_delta_en & ~write_q;
      write_q   <= write_delta_en;
    end
  end

  assign rd_addr   = rd_q;
  assign wr_addr   = wr_addr_q;
  assign wr_en     = wr_en_q;
  assign cep_idx   = cep_q;
  assign frame_idx = frame_q;

endmodule

// File: tb/tb_delta_addr_gen.sv
// Directed bench for delta_addr_gen with a 13-coefficient x 4-frame geometry.
module tb_delta_addr_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, counter_en = 1'b0, sel_addr = 1'b0;
  logic        inc_cep_en = 1'b0, inc_frame_en = 1'b0, write_delta_en = 1'b0;
  logic [3:0]  counter_value = 4'd0;
  logic [1:0]  sel_n = 2'b00;
  logic        counter_over, counter_cep_over, counter_frame_over, wr_en;
  logic [10:0] rd_addr, wr_addr;
  logic [3:0]  cep_idx;
  logic [6:0]  frame_idx;

  int total = 0;
  int bad = 0;
  logic mon = 1'b0;
  logic [10:0] wq[$];

  delta_addr_gen #(.NUM_CEP(13), .NUM_FRAME(4), .CEP_AW(4), .FRAME_AW(7), .ADDR_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .start(start), .counter_en(counter_en), .counter_value(counter_value),
    .sel_n(sel_n), .sel_addr(sel_addr), .inc_cep_en(inc_cep_en), .inc_frame_en(inc_frame_en),
    .write_delta_en(write_delta_en), .counter_over(counter_over), .counter_cep_over(counter_cep_over),
    .counter_frame_over(counter_frame_over), .rd_addr(rd_addr), .wr_addr(wr_addr), .wr_en(wr_en),
    .cep_idx(cep_idx), .frame_idx(frame_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon && wr_en) wq.push_back(wr_addr);

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic goto(input int f, input int c);
    start = 1'b1; step(); start = 1'b0;
    inc_frame_en = 1'b1; inc_cep_en = 1'b1;
    repeat (f) step();
    inc_frame_en = 1'b0;
    repeat (c) step();
    inc_cep_en = 1'b0;
  endtask

  task automatic test_reset();
    int hit;
    step();
    total++; if (rd_addr !== 11'd0) begin bad++; $display("FAIL rst_rd_addr got=%0d exp=0", rd_addr); end
    total++; if (wr_en !== 1'b0 || counter_over !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b exp=00", wr_en, counter_over); end
    total++; if (counter_cep_over !== 1'b0 || counter_frame_over !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", counter_cep_over, counter_frame_over); end
    rst = 1'b0;
    inc_cep_en = 1'b1; step(); step(); inc_cep_en = 1'b0;
    counter_en = 1'b1; counter_value = 4'd5; step(); step();
    total++; if (rd_addr !== 11'd2) begin bad++; $display("FAIL pre_rst_rd_addr got=%0d exp=2", rd_addr); end
    #1 rst = 1'b1; #1;
    total++; if (rd_addr !== 11'd0 || cep_idx !== 4'd0) begin bad++; $display("FAIL async_rst got=%0d/%0d exp=0/0", rd_addr, cep_idx); end
    total++; if (counter_over !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL async_rst_strobes got=%b%b exp=00", counter_over, wr_en); end
    step(); rst = 1'b0;
    hit = -1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (counter_over && hit < 0) hit = i;
      step();
    end
    total++; if (hit !== 4) begin bad++; $display("FAIL rst_cnt_restart got=%0d exp=4", hit); end
    counter_en = 1'b0; step();
  endtask

  task automatic test_counter();
    counter_value = 4'd3; counter_en = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      #1;
      total++; if (counter_over !== (c % 3 == 0)) begin bad++; $display("FAIL cnt3 cycle=%0d got=%b exp=%b", c, counter_over, (c % 3 == 0)); end
      step();
    end
    counter_en = 1'b0; step();
    counter_value = 4'd0; counter_en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      total++; if (counter_over !== 1'b1) begin bad++; $display("FAIL cnt0 cycle=%0d got=%b exp=1", c, counter_over); end
      step();
    end
    counter_en = 1'b0; #1;
    total++; if (counter_over !== 1'b0) begin bad++; $display("FAIL cnt_off got=%b exp=0", counter_over); end
    step();
  endtask

  task automatic test_clamp();
    logic [1:0]  sels[4] = '{2'b10, 2'b00, 2'b11, 2'b01};
    logic [10:0] exp0[4] = '{11'd5, 11'd5, 11'd31, 11'd18};
    goto(0, 5);
    for (int i = 0; i < 4; i++) begin
      sel_n = sels[i]; step();
      total++; if (rd_addr !== exp0[i]) begin bad++; $display("FAIL clamp_f0 sel=%b got=%0d exp=%0d", sels[i], rd_addr, exp0[i]); end
    end
    goto(3, 5);
    total++; if (counter_frame_over !== 1'b1) begin bad++; $display("FAIL frame_over got=%b exp=1", counter_frame_over); end
    sel_n = 2'b11; step();
    total++; if (rd_addr !== 11'd44) begin bad++; $display("FAIL clamp_f3_np2 got=%0d exp=44", rd_addr); end
    sel_n = 2'b10; step();
    total++; if (rd_addr !== 11'd18) begin bad++; $display("FAIL clamp_f3_nm2 got=%0d exp=18", rd_addr); end
    sel_n = 2'b00;
  endtask

  task automatic test_inc_frame();
    goto(1, 12);
    total++; if (counter_cep_over !== 1'b1) begin bad++; $display("FAIL cep_over_pre got=%b exp=1", counter_cep_over); end
    inc_frame_en = 1'b1; inc_cep_en = 1'b1; step(); inc_frame_en = 1'b0; inc_cep_en = 1'b0;
    total++; if (frame_idx !== 7'd2 || cep_idx !== 4'd0) begin bad++; $display("FAIL inc_frame got=%0d/%0d exp=2/0", frame_idx, cep_idx); end
    total++; if (counter_cep_over !== 1'b0) begin bad++; $display("FAIL cep_over_post got=%b exp=0", counter_cep_over); end
    sel_addr = 1'b1; step();
    total++; if (rd_addr !== 11'd26) begin bad++; $display("FAIL cur_frame_addr got=%0d exp=26", rd_addr); end
    sel_addr = 1'b0;
  endtask

  task automatic test_write();
    goto(2, 4);
    write_delta_en = 1'b1; step();
    total++; if (wr_en !== 1'b1 || wr_addr !== 11'd30) begin bad++; $display("FAIL write1 got=%b/%0d exp=1/30", wr_en, wr_addr); end
    step();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL write_hold got=%b exp=0", wr_en); end
    write_delta_en = 1'b0; step();
    write_delta_en = 1'b1; step();
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL write2 got=%b exp=1", wr_en); end
    write_delta_en = 1'b0; step();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL write2_end got=%b exp=0", wr_en); end
  endtask

  task automatic test_sweep();
    int both = 0, both_at = -1;
    goto(0, 0);
    wq.delete(); mon = 1'b1;
    for (int i = 0; i < 52; i++) begin
      write_delta_en = 1'b1; step(); step(); write_delta_en = 1'b0;
      if (counter_cep_over && counter_frame_over) begin both++; both_at = i; end
      if (i != 51) begin
        inc_cep_en = 1'b1; inc_frame_en = counter_cep_over;
      end
      step(); inc_cep_en = 1'b0; inc_frame_en = 1'b0;
    end
    step(); mon = 1'b0;
    total++; if (both !== 1 || both_at !== 51) begin bad++; $display("FAIL sweep_last got=%0d@%0d exp=1@51", both, both_at); end
    total++; if (wq.size() !== 52) begin bad++; $display("FAIL sweep_pulses got=%0d exp=52", wq.size()); end
    for (int i = 0; i < 52 && i < wq.size(); i++) begin
      total++; if (wq[i] !== 11'(i)) begin bad++; $display("FAIL sweep_addr idx=%0d got=%0d exp=%0d", i, wq[i], i); end
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_clamp();
    test_inc_frame();
    test_write();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
